matrix_alloc: RTL and testbench

MATRIX_ALLOC -- requirements
Module: matrix_alloc

---
 rtl/matrix_pkg.sv | 41 ++++
 rtl/matrix_alloc_if.sv | 25 ++
 rtl/matrix_slot_table.sv | 50 +++++
 rtl/matrix_alloc.sv | 154 +++++++++++++++
 tb/tb_matrix_alloc.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_pkg.sv
// Shared constants, state encoding and address helpers for the
// matrix slot allocator.
package matrix_pkg;

    localparam int DIM_MAX         = 5;
    localparam int CLASS_NUM       = 25;
    localparam int SLOTS_PER_CLASS = 2;
    localparam int CLS_W           = 5;

    // First word of each class region; each region is 2*m*n words
    localparam int REGION_BASE [CLASS_NUM] = '{
          0,   2,   6,  12,  20,
         30,  34,  42,  54,  70,
         90,  96, 108, 126, 150,
        180, 188, 204, 228, 260,
        300, 310, 330, 360, 400
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_GRANT,
        S_WAIT_COMMIT
    } state_t;

    function automatic logic [CLS_W-1:0] cls_of(
        input logic [2:0] m,
        input logic [2:0] n
    );
        return CLS_W'((int'(m) - 1) * DIM_MAX + int'(n) - 1);
    endfunction

    function automatic int slot_base(
        input logic [2:0] m,
        input logic [2:0] n,
        input logic       k
    );
        return REGION_BASE[cls_of(m, n)] + (k ? int'(m) * int'(n) : 0);
    endfunction

endpackage

// File: rtl/matrix_alloc_if.sv
// Request/grant handshake between the input stage and the
// matrix slot allocator.
interface matrix_alloc_if #(
    parameter int ADDR_W = 9
);
    logic              i_dims_valid;
    logic [31:0]       i_dim_m;
    logic [31:0]       i_dim_n;
    logic              i_rx_done;
    logic              i_abort;
    logic [ADDR_W-1:0] o_base_addr;
    logic              o_addr_ready;
    logic              o_alloc_err;
    logic              o_busy;

    modport master (
        output i_dims_valid, i_dim_m, i_dim_n, i_rx_done, i_abort,
        input  o_base_addr, o_addr_ready, o_alloc_err, o_busy
    );

    modport slave (
        input  i_dims_valid, i_dim_m, i_dim_n, i_rx_done, i_abort,
        output o_base_addr, o_addr_ready, o_alloc_err, o_busy
    );
endinterface

// File: rtl/matrix_slot_table.sv
// Per-class slot valid bits and older-slot pointer with victim select,
// lookup read and a single commit/clear write port.
module matrix_slot_table
    import matrix_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [CLS_W-1:0] i_vs_cls,
    output logic             o_vs_slot,
    input  logic [CLS_W-1:0] i_lk_cls,
    output logic [1:0]       o_lk_valid,
    input  logic             i_wr_en,
    input  logic             i_wr_set,
    input  logic [CLS_W-1:0] i_wr_cls,
    input  logic             i_wr_slot
);
    logic [CLASS_NUM-1:0][1:0] r_valid;
    logic [CLASS_NUM-1:0]      r_older;
    logic [1:0]                w_v;
    logic                      w_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_older <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_cls][i_wr_slot] <= i_wr_set;
            if (i_wr_set) begin
                r_older[i_wr_cls] <= ~i_wr_slot;
            end
        end
    end

    // Victim sees a same-cycle write so back-to-back requests on one
    // class do not pick the slot being committed.
    always_comb begin
        w_v = r_valid[i_vs_cls];
        w_o = r_older[i_vs_cls];
        if (i_wr_en && (i_wr_cls == i_vs_cls)) begin
            w_v[i_wr_slot] = i_wr_set;
            if (i_wr_set) begin
                w_o = ~i_wr_slot;
            end
        end
        o_vs_slot = !w_v[0] ? 1'b0 : (!w_v[1] ? 1'b1 : w_o);
    end

    assign o_lk_valid = r_valid[i_lk_cls];

endmodule

// File: rtl/matrix_alloc.sv
// Matrix slot allocator: maps (m,n) requests onto two slots per size
// class, grants a base address and tracks commit/abort of the slot.
module matrix_alloc #(
    parameter int ADDR_W  = 9,
    parameter int DIM_MAX = matrix_pkg::DIM_MAX
) (
    input  logic              clk,
    input  logic              rst,
    matrix_alloc_if.slave     bus,
    input  logic [2:0]        i_q_m,
    input  logic [2:0]        i_q_n,
    input  logic              i_q_idx,
    output logic [ADDR_W-1:0] o_q_base,
    output logic              o_q_hit,
    output logic [1:0]        o_q_count
);
    import matrix_pkg::*;

    state_t            r_state;
    logic              r_dv_q;
    logic [2:0]        r_m;
    logic [2:0]        r_n;
    logic [CLS_W-1:0]  r_cls;
    logic              r_slot;
    logic [ADDR_W-1:0] r_base;
    logic              r_rdy;
    logic              r_err;
    logic [ADDR_W-1:0] r_q_base;
    logic              r_q_hit;
    logic [1:0]        r_q_count;

    logic              w_edge;
    logic              w_legal;
    logic              w_new;
    logic [CLS_W-1:0]  w_cls_new;
    logic              w_vs_slot;
    logic              w_we;
    logic              w_clr;
    logic              w_q_ok;
    logic [2:0]        w_qm;
    logic [2:0]        w_qn;
    logic [1:0]        w_lk_valid;

    always_comb begin
        w_edge    = bus.i_dims_valid & ~r_dv_q;
        w_legal   = (bus.i_dim_m >= 32'd1) && (bus.i_dim_m <= 32'(DIM_MAX))
                 && (bus.i_dim_n >= 32'd1) && (bus.i_dim_n <= 32'(DIM_MAX));
        w_new     = w_edge && w_legal;
        w_cls_new = w_legal ? cls_of(bus.i_dim_m[2:0], bus.i_dim_n[2:0]) : '0;
        w_we      = 1'b0;
        w_clr     = 1'b0;
        if (r_state == S_WAIT_COMMIT) begin
            if (bus.i_abort) begin
                w_clr = 1'b1;
            end else if (bus.i_rx_done || w_new) begin
                w_we = 1'b1;
            end
        end
        w_q_ok = (i_q_m >= 3'd1) && (int'(i_q_m) <= DIM_MAX)
              && (i_q_n >= 3'd1) && (int'(i_q_n) <= DIM_MAX);
        w_qm   = w_q_ok ? i_q_m : 3'd1;
        w_qn   = w_q_ok ? i_q_n : 3'd1;
    end

    matrix_slot_table u_tbl (
        .clk        (clk),
        .rst        (rst),
        .i_vs_cls   (w_cls_new),
        .o_vs_slot  (w_vs_slot),
        .i_lk_cls   (cls_of(w_qm, w_qn)),
        .o_lk_valid (w_lk_valid),
        .i_wr_en    (w_we | w_clr),
        .i_wr_set   (w_we),
        .i_wr_cls   (r_cls),
        .i_wr_slot  (r_slot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_dv_q  <= 1'b0;
            r_m     <= 3'd0;
            r_n     <= 3'd0;
            r_cls   <= '0;
            r_slot  <= 1'b0;
            r_base  <= '0;
            r_rdy   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_dv_q <= bus.i_dims_valid;
            r_rdy  <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_new) begin
                        r_m     <= bus.i_dim_m[2:0];
                        r_n     <= bus.i_dim_n[2:0];
                        r_cls   <= w_cls_new;
                        r_slot  <= w_vs_slot;
                        r_state <= S_LOOKUP;
                    end else if (w_edge) begin
                        r_err <= 1'b1;
                    end
                end
                S_LOOKUP: begin
                    if (bus.i_abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_base  <= ADDR_W'(slot_base(r_m, r_n, r_slot));
                        r_rdy   <= 1'b1;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_state <= bus.i_abort ? S_IDLE : S_WAIT_COMMIT;
                end
                S_WAIT_COMMIT: begin
                    if (bus.i_abort) begin
                        r_state <= S_IDLE;
                    end else if (w_new) begin
                        r_m     <= bus.i_dim_m[2:0];
                        r_n     <= bus.i_dim_n[2:0];
                        r_cls   <= w_cls_new;
                        r_slot  <= w_vs_slot;
                        r_state <= S_LOOKUP;
                    end else if (bus.i_rx_done) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_base  <= '0;
            r_q_hit   <= 1'b0;
            r_q_count <= 2'd0;
        end else begin
            r_q_hit   <= w_q_ok & w_lk_valid[i_q_idx];
            r_q_count <= w_q_ok ? 2'(w_lk_valid[0]) + 2'(w_lk_valid[1]) : 2'd0;
            r_q_base  <= w_q_ok ? ADDR_W'(slot_base(w_qm, w_qn, i_q_idx)) : '0;
        end
    end

    assign bus.o_base_addr  = r_base;
    assign bus.o_addr_ready = r_rdy;
    assign bus.o_alloc_err  = r_err;
    assign bus.o_busy       = (r_state != S_IDLE);
    assign o_q_base         = r_q_base;
    assign o_q_hit          = r_q_hit;
    assign o_q_count        = r_q_count;

endmodule

// File: tb/tb_matrix_alloc.sv
// Scoreboard bench for matrix_alloc: directed scenarios then random
// traffic against a least-recently-committed slot model.
module tb_matrix_alloc;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matrix_alloc_if #(.ADDR_W(9)) bus ();
    logic [2:0] q_m;
    logic [2:0] q_n;
    logic       q_idx;
    logic [8:0] q_base;
    logic       q_hit;
    logic [1:0] q_count;

    matrix_alloc #(.ADDR_W(9), .DIM_MAX(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .i_q_m     (q_m),
        .i_q_n     (q_n),
        .i_q_idx   (q_idx),
        .o_q_base  (q_base),
        .o_q_hit   (q_hit),
        .o_q_count (q_count)
    );

    typedef struct { int base; int cyc; } gexp_t;
    typedef struct { int hit; int cnt; int base; } qexp_t;

    gexp_t gq[$];
    int    eq[$];
    qexp_t qq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit mon_en = 0;
    bit q_chk  = 0;

    // Reference model: per (m,n) two slots, each with valid and the
    // time it was last committed; victim is the least recently committed.
    bit vld [6][6][2];
    int stp [6][6][2];
    int gst;
    bit pend;
    int pm, pn, pk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int rbase(int m, int n);
        int s = 0;
        for (int mm = 1; mm <= 5; mm++)
            for (int nn = 1; nn <= 5; nn++)
                if ((mm - 1) * 5 + nn - 1 < (m - 1) * 5 + n - 1) s += 2 * mm * nn;
        return s;
    endfunction

    function automatic bit legal(int v);
        return v >= 1 && v <= 5;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 6; a++)
            for (int b = 0; b < 6; b++)
                for (int k = 0; k < 2; k++) begin
                    vld[a][b][k] = 0;
                    stp[a][b][k] = 0;
                end
        gst  = 0;
        pend = 0;
    endtask

    task automatic model_commit();
        if (pend) begin
            gst++;
            vld[pm][pn][pk] = 1;
            stp[pm][pn][pk] = gst;
            pend = 0;
        end
    endtask

    always @(negedge clk) begin
        gexp_t g;
        qexp_t q;
        int e;
        if (mon_en) begin
            if (bus.o_addr_ready === 1'b1) begin
                if (gq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL grant_unexpected: base %0d, no grant required", bus.o_base_addr);
                end else begin
                    g = gq.pop_front();
                    chk("grant_base", int'(bus.o_base_addr), g.base);
                    chk("grant_cycle", cyc, g.cyc);
                end
            end
            if (bus.o_alloc_err === 1'b1) begin
                if (eq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL err_unexpected: alloc_err high, none required");
                end else begin
                    e = eq.pop_front();
                    chk("err_cycle", cyc, e);
                end
            end
            if (q_chk && qq.size() != 0) begin
                q = qq.pop_front();
                chk("q_hit", int'(q_hit), q.hit);
                chk("q_count", int'(q_count), q.cnt);
                chk("q_base", int'(q_base), q.base);
            end
        end
    end

    task automatic do_req(int m, int n, int hold);
        int c0 = cyc;
        int k;
        if (legal(m) && legal(n)) begin
            model_commit();
            if (!vld[m][n][0]) k = 0;
            else if (!vld[m][n][1]) k = 1;
            else k = (stp[m][n][0] <= stp[m][n][1]) ? 0 : 1;
            gq.push_back('{rbase(m, n) + k * m * n, c0 + 2});
            pend = 1;
            pm = m; pn = n; pk = k;
        end else begin
            eq.push_back(c0 + 1);
        end
        bus.i_dim_m      = 32'(m);
        bus.i_dim_n      = 32'(n);
        bus.i_dims_valid = 1'b1;
        tick(hold);
        bus.i_dims_valid = 1'b0;
        tick(1);
        while (cyc < c0 + 3) tick(1);
    endtask

    task automatic req_abort_lookup(int m, int n);
        bus.i_dim_m      = 32'(m);
        bus.i_dim_n      = 32'(n);
        bus.i_dims_valid = 1'b1;
        tick(1);
        bus.i_dims_valid = 1'b0;
        bus.i_abort      = 1'b1;
        tick(1);
        bus.i_abort = 1'b0;
        tick(2);
    endtask

    task automatic rx_done();
        bus.i_rx_done = 1'b1;
        tick(1);
        bus.i_rx_done = 1'b0;
        model_commit();
        tick(1);
    endtask

    task automatic abort(bit with_rx);
        bus.i_abort   = 1'b1;
        bus.i_rx_done = with_rx;
        tick(1);
        bus.i_abort   = 1'b0;
        bus.i_rx_done = 1'b0;
        if (pend) begin
            vld[pm][pn][pk] = 0;
            pend = 0;
        end
        tick(1);
    endtask

    task automatic query(int m, int n, bit idx);
        bit ok = legal(m) && legal(n);
        qexp_t e;
        e.hit  = ok ? int'(vld[m][n][idx]) : 0;
        e.cnt  = ok ? int'(vld[m][n][0]) + int'(vld[m][n][1]) : 0;
        e.base = ok ? rbase(m, n) + (idx ? m * n : 0) : 0;
        qq.push_back(e);
        q_m   = 3'(m);
        q_n   = 3'(n);
        q_idx = idx;
        tick(1);
        q_chk = 1'b1;
        tick(1);
        q_chk = 1'b0;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_base"}, int'(bus.o_base_addr), 0);
        chk({tag, "_ready"}, int'(bus.o_addr_ready), 0);
        chk({tag, "_err"}, int'(bus.o_alloc_err), 0);
        chk({tag, "_busy"}, int'(bus.o_busy), 0);
        chk({tag, "_qbase"}, int'(q_base), 0);
        chk({tag, "_qhit"}, int'(q_hit), 0);
        chk({tag, "_qcount"}, int'(q_count), 0);
    endtask

    initial begin
        int bad_vals [5] = '{0, 6, 7, 100, -1};
        rst              = 1'b1;
        bus.i_dims_valid = 1'b0;
        bus.i_dim_m      = 32'd0;
        bus.i_dim_n      = 32'd0;
        bus.i_rx_done    = 1'b0;
        bus.i_abort      = 1'b0;
        q_m   = 3'd1;
        q_n   = 3'd1;
        q_idx = 1'b0;
        model_reset();
        tick(3);
        chk_zero("reset");
        rst = 1'b0;
        tick(1);
        mon_en = 1'b1;

        do_req(2, 3, 1);
        chk("busy_wait", int'(bus.o_busy), 1);
        rx_done();
        query(2, 3, 0);

        do_req(2, 3, 1);
        rx_done();
        do_req(2, 3, 1);
        rx_done();
        query(2, 3, 1);

        do_req(1, 1, 1);
        abort(0);
        query(1, 1, 0);
        chk("busy_after_abort", int'(bus.o_busy), 0);

        do_req(6, 2, 1);
        chk("busy_after_err", int'(bus.o_busy), 0);

        do_req(5, 5, 1);
        do_req(5, 5, 1);
        rx_done();
        query(5, 5, 0);
        query(5, 5, 1);

        do_req(1, 2, 4);
        rx_done();

        req_abort_lookup(3, 3);
        chk("busy_lookup_abort", int'(bus.o_busy), 0);
        query(3, 3, 0);

        do_req(1, 3, 1);
        rst = 1'b1;
        tick(1);
        chk_zero("rst_wait");
        rst = 1'b0;
        model_reset();
        tick(1);
        query(1, 3, 0);

        for (int it = 0; it < 300; it++) begin
            int op;
            int m;
            int n;
            op = $urandom_range(0, 11);
            m  = $urandom_range(1, 5);
            n  = $urandom_range(1, 5);
            if (op <= 3) begin
                do_req(m, n, $urandom_range(1, 4));
            end else if (op == 4 && !pend) begin
                if ($urandom_range(0, 1) == 1) m = bad_vals[$urandom_range(0, 4)];
                else n = bad_vals[$urandom_range(0, 4)];
                do_req(m, n, 1);
            end else if (op <= 6) begin
                rx_done();
            end else if (op == 7) begin
                abort($urandom_range(0, 1) == 1);
            end else if (op == 8 && !pend) begin
                req_abort_lookup(m, n);
            end else begin
                query($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
            end
        end

        tick(4);
        chk("grants_drained", gq.size(), 0);
        chk("errs_drained", eq.size(), 0);
        chk("queries_drained", qq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
